// File: rtl/sipo_framer_pkg.sv
// sipo_framer_pkg: shared state encoding and widths for the SIPO word framer.
// Revision 1.0
`default_nettype none

package sipo_framer_pkg;

   typedef enum logic {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   localparam int DROP_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/sipo_framer_outreg.sv
// sipo_framer_outreg: one-entry valid/ready output register with sticky overflow.
// Optional SIPO_FRAMER_DROP_CNT_EN adds a saturating dropped-word counter. Revision 1.0
`default_nettype none

module sipo_framer_outreg
   import sipo_framer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [WIDTH-1:0]      word,
   input  logic                  m_ready,
   input  logic                  clr_ovf,
   output logic [WIDTH-1:0]      m_data,
   output logic                  m_valid,
`ifdef SIPO_FRAMER_DROP_CNT_EN
   output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
   output logic                  overflow
);

   logic [WIDTH-1:0] m_data_d, m_data_q;
   logic             m_valid_d, m_valid_q;
   logic             overflow_d, overflow_q;
   logic             accept;
   logic             drop;

   always_comb begin
      // A slot frees up in the same cycle it is consumed, so back-to-back loads never bubble.
      accept     = load && (!m_valid_q || m_ready);
      drop       = load && !accept;
      m_data_d   = m_data_q;
      m_valid_d  = m_valid_q;
      overflow_d = overflow_q;
      if (accept) begin
         m_data_d  = word;
         m_valid_d = 1'b1;
      end else if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data_q   <= '0;
         m_valid_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         m_data_q   <= m_data_d;
         m_valid_q  <= m_valid_d;
         overflow_q <= overflow_d;
      end
   end

   assign m_data   = m_data_q;
   assign m_valid  = m_valid_q;
   assign overflow = overflow_q;

`ifdef SIPO_FRAMER_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt_d, drop_cnt_q;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (clr_ovf) begin
         drop_cnt_d = drop ? DROP_CNT_W'(1) : '0;
      end else if (drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: rtl/sipo_word_framer.sv
// sipo_word_framer: hunts for SYNC_WORD in a shift register stream, then frames WIDTH-bit words.
// Optional SIPO_FRAMER_DROP_CNT_EN exposes drop_cnt. Revision 1.0
`default_nettype none

module sipo_word_framer
   import sipo_framer_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] SYNC_WORD = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [WIDTH-1:0]      q,
   input  logic                  resync,
   input  logic                  clr_ovf,
   output logic [WIDTH-1:0]      m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  locked,
`ifdef SIPO_FRAMER_DROP_CNT_EN
   output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
   output logic                  overflow
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_d, state_q;
   logic [CNT_W-1:0] bit_cnt_d, bit_cnt_q;
   logic             en_d_q;
   logic             load;

   // en_d_q marks the cycle in which q already carries the newly shifted bit.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      load      = 1'b0;
      if (resync) begin
         state_d   = ST_HUNT;
         bit_cnt_d = '0;
      end else if (en_d_q) begin
         case (state_q)
            ST_HUNT: begin
               if (q == SYNC_WORD) begin
                  state_d   = ST_LOCKED;
                  bit_cnt_d = '0;
               end
            end
            ST_LOCKED: begin
               if (bit_cnt_q == CNT_LAST) begin
                  load      = 1'b1;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_HUNT;
         bit_cnt_q <= '0;
         en_d_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         en_d_q    <= en;
      end
   end

   assign locked = (state_q == ST_LOCKED);

   sipo_framer_outreg #(
      .WIDTH (WIDTH)
   ) u_outreg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .word     (q),
      .m_ready  (m_ready),
      .clr_ovf  (clr_ovf),
      .m_data   (m_data),
      .m_valid  (m_valid),
`ifdef SIPO_FRAMER_DROP_CNT_EN
      .drop_cnt (drop_cnt),
`endif
      .overflow (overflow)
   );

endmodule

`default_nettype wire

// File: tb/tb_sipo_word_framer.sv
// tb_sipo_word_framer: directed and random stimulus checked against a stream-level reference model.
// Revision 1.0
`default_nettype none

module tb_sipo_word_framer;

   localparam int         W    = 8;
   localparam logic [7:0] SYNC = 8'hA5;

   logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, sin = 1'b0;
   logic       resync = 1'b0, clr_ovf = 1'b0, m_ready = 1'b0;
   logic [7:0] sr = '0;
   logic [7:0] m_data;
   logic       m_valid, locked, overflow;
`ifdef SIPO_FRAMER_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Upstream shift register: newest bit enters at q[0].
   always @(posedge clk) if (en) sr <= {sr[6:0], sin};

   sipo_word_framer #(.WIDTH(W), .SYNC_WORD(SYNC)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .q        (sr),
      .resync   (resync),
      .clr_ovf  (clr_ovf),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .locked   (locked),
`ifdef SIPO_FRAMER_DROP_CNT_EN
      .drop_cnt (drop_cnt),
`endif
      .overflow (overflow)
   );

   // Reference model: bit stream history, bits-since-sync count, and a one-deep output queue.
   bit         md_ev, md_hunt;
   int         md_nbits, md_drops;
   logic [7:0] md_w = '0;
   logic [7:0] md_q[$];
   logic [7:0] md_dat;
   bit         md_ovf;
   logic [7:0] got[$];
   logic [7:0] sent[$];
   bit         obs_v;
   logic [7:0] obs_d;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      md_ev    = 1'b0;
      md_hunt  = 1'b1;
      md_nbits = 0;
      md_q.delete();
      md_dat   = '0;
      md_ovf   = 1'b0;
      md_drops = 0;
      obs_v    = 1'b0;
   endtask

   task automatic model_edge();
      bit cap, drop;
      cap  = 1'b0;
      drop = 1'b0;
      if (resync) begin
         md_hunt = 1'b1;
      end else if (md_ev) begin
         if (md_hunt) begin
            if (md_w == SYNC) begin
               md_hunt  = 1'b0;
               md_nbits = 0;
            end
         end else begin
            md_nbits++;
            cap = (md_nbits % W) == 0;
         end
      end
      if (md_q.size() != 0 && m_ready) void'(md_q.pop_front());
      if (cap) begin
         if (md_q.size() == 0) begin
            md_q.push_back(md_w);
            md_dat = md_w;
         end else begin
            drop = 1'b1;
         end
      end
      if (drop) md_ovf = 1'b1;
      else if (clr_ovf) md_ovf = 1'b0;
      if (clr_ovf) md_drops = drop ? 1 : 0;
      else if (drop && md_drops < 255) md_drops++;
      if (en) md_w = {md_w[6:0], sin};
      md_ev = en;
   endtask

   task automatic step();
      @(posedge clk);
      if (obs_v && m_ready) got.push_back(obs_d);
      if (!rst_n) model_reset();
      else model_edge();
      @(negedge clk);
      chk("valid", m_valid, md_q.size() != 0);
      chk("data", m_data, md_dat);
      chk("locked", locked, !md_hunt);
      chk("overflow", overflow, md_ovf);
`ifdef SIPO_FRAMER_DROP_CNT_EN
      chk("drop_cnt", drop_cnt, md_drops);
`endif
      obs_v = m_valid;
      obs_d = m_data;
   endtask

   task automatic send_byte(input logic [7:0] v, input int gap);
      for (int i = 7; i >= 0; i--) begin
         en  = 1'b1;
         sin = v[i];
         step();
         en  = 1'b0;
         repeat (gap) step();
      end
   endtask

   task automatic do_resync();
      resync = 1'b1;
      step();
      resync = 1'b0;
   endtask

   initial begin
      model_reset();
      step();
      step();
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_locked", locked, 0);
      chk("rst_ovf", overflow, 0);
      rst_n = 1'b1;

      // 1: sync then one word at full rate, latency and single-cycle valid
      m_ready = 1'b1;
      got.delete();
      send_byte(SYNC, 0);
      chk("t1_not_locked_yet", locked, 0);
      send_byte(8'h3C, 0);
      chk("t1_lat1", m_valid, 0);
      step();
      chk("t1_lat2", m_valid, 1);
      chk("t1_data", m_data, 8'h3C);
      step();
      chk("t1_one_cycle", m_valid, 0);
      chk("t1_count", got.size(), 1);

      // 2: 1-of-3 duty cycle, nothing before the sync word
      do_resync();
      got.delete();
      send_byte(8'h00, 2);
      send_byte(SYNC, 2);
      chk("t2_no_early", got.size(), 0);
      send_byte(8'h11, 2);
      send_byte(8'h22, 2);
      send_byte(8'h33, 2);
      repeat (3) step();
      chk("t2_count", got.size(), 3);
      if (got.size() == 3) begin
         chk("t2_w0", got[0], 8'h11);
         chk("t2_w1", got[1], 8'h22);
         chk("t2_w2", got[2], 8'h33);
      end

      // 3: backpressure drop, later acceptance, overflow clear
      m_ready = 1'b0;
      do_resync();
      got.delete();
      send_byte(SYNC, 0);
      send_byte(8'h44, 0);
      send_byte(8'h55, 0);
      repeat (2) step();
      chk("t3_data_held", m_data, 8'h44);
      chk("t3_ovf", overflow, 1);
`ifdef SIPO_FRAMER_DROP_CNT_EN
      chk("t3_drop_cnt", drop_cnt, 1);
`endif
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      chk("t3_count", got.size(), 1);
      if (got.size() == 1) chk("t3_word", got[0], 8'h44);
      chk("t3_valid_gone", m_valid, 0);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      chk("t3_ovf_clr", overflow, 0);

      // 4: resync coincident with the 4th bit event of a word
      m_ready = 1'b1;
      do_resync();
      got.delete();
      send_byte(SYNC, 0);
      for (int i = 0; i < 4; i++) begin
         en  = 1'b1;
         sin = 1'b0;
         step();
      end
      en     = 1'b0;
      resync = 1'b1;
      step();
      resync = 1'b0;
      chk("t4_unlocked", locked, 0);
      for (int i = 0; i < 4; i++) begin
         en  = 1'b1;
         sin = 1'b1;
         step();
      end
      en = 1'b0;
      send_byte(SYNC, 0);
      send_byte(8'h66, 0);
      repeat (3) step();
      chk("t4_count", got.size(), 1);
      if (got.size() == 1) chk("t4_word", got[0], 8'h66);

      // 5: asynchronous reset mid-word with a pending word
      m_ready = 1'b0;
      do_resync();
      send_byte(SYNC, 0);
      send_byte(8'h77, 0);
      for (int i = 0; i < 3; i++) begin
         en  = 1'b1;
         sin = 1'b0;
         step();
      end
      en = 1'b0;
      step();
      chk("t5_pending", m_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_async_valid", m_valid, 0);
      chk("t5_async_data", m_data, 0);
      chk("t5_async_locked", locked, 0);
      chk("t5_async_ovf", overflow, 0);
      model_reset();
      step();
      step();
      rst_n   = 1'b1;
      m_ready = 1'b1;
      got.delete();
      send_byte(8'h77, 0);
      repeat (2) step();
      chk("t5_still_hunt", locked, 0);
      chk("t5_no_words", got.size(), 0);
      send_byte(SYNC, 0);
      send_byte(8'h99, 0);
      repeat (3) step();
      chk("t5_count", got.size(), 1);
      if (got.size() == 1) chk("t5_word", got[0], 8'h99);

      // 6: ten back-to-back words at full rate
      do_resync();
      got.delete();
      sent.delete();
      send_byte(SYNC, 0);
      for (int k = 0; k < 10; k++) begin
         logic [7:0] v;
         v = 8'($urandom);
         sent.push_back(v);
         send_byte(v, 0);
      end
      repeat (3) step();
      chk("t6_count", got.size(), 10);
      if (got.size() == 10) begin
         for (int k = 0; k < 10; k++) chk("t6_word", got[k], sent[k]);
      end
      chk("t6_no_ovf", overflow, 0);

      // Random traffic: sync words, gaps, backpressure, resync and clears
      for (int c = 0; c < 300; c++) begin
         logic [7:0] v;
         v = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
         for (int i = 7; i >= 0; i--) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g <= gap; g++) begin
               en      = (g == 0);
               sin     = v[i];
               m_ready = ($urandom_range(0, 3) != 0);
               resync  = ($urandom_range(0, 199) == 0);
               clr_ovf = ($urandom_range(0, 31) == 0);
               step();
            end
         end
      end
      en      = 1'b0;
      resync  = 1'b0;
      clr_ovf = 1'b0;
      m_ready = 1'b1;
      repeat (4) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sipo_word_framer.md
Name: sipo_word_framer

Overview:
- Downstream consumer of the serial-in/parallel-out shift register.
- Watches the same shift-enable strobe and the register's parallel output.
- Hunts for a sync word, then captures every subsequent WIDTH-bit word.
- Presents each captured word on a valid/ready output port, with overflow detection.

Parameters:
WIDTH, 8, word width; must match the shift register width; minimum 2.
SYNC_WORD, 8'hA5 (WIDTH bits), pattern that establishes word alignment.

Ports:
clk  input  1  rising-edge clock; same clock as the shift register.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  shift strobe; the same signal that drives the shift register's en.
q  input  WIDTH  shift register parallel output; q[0] holds the newest bit.
resync  input  1  force a return to hunting.
clr_ovf  input  1  clears the overflow flag.
m_data  output  WIDTH  captured word.
m_valid  output  1  m_data holds an unconsumed word.
m_ready  input  1  downstream accepts the word.
locked  output  1  high while in the LOCKED state.
overflow  output  1  sticky flag: a word was dropped.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=HUNT, en_d=0, bit_cnt=0, m_valid=0, m_data=0, locked=0, overflow=0.
- Bit event:
  - en_d is en registered by one clock.
  - A bit event is any cycle with en_d=1.
  - During a bit event, q already reflects the newly shifted bit.
- HUNT state:
  - On a bit event with q==SYNC_WORD, move to LOCKED and set bit_cnt=0.
  - Otherwise stay in HUNT.
  - No words are captured in HUNT.
- LOCKED state:
  - locked=1.
  - Each bit event increments bit_cnt.
  - On the bit event where bit_cnt==WIDTH-1, capture q and set bit_cnt=0.
  - Result: one capture per WIDTH bits after the sync word.
- bit_cnt is $clog2(WIDTH) bits wide; it returns to 0 explicitly, never by natural wrap.
- Capture / handshake:
  - Load m_data=q and set m_valid=1 if m_valid==0, or if m_valid&&m_ready in the same cycle (back-to-back, no bubble).
  - Otherwise discard the new word, keep m_data, and set overflow=1.
  - A transfer is m_valid&&m_ready with no capture that cycle; it sets m_valid=0 next cycle.
  - While m_valid=1, m_data is stable.
- Latency: en high in cycle t (last bit of a word) -> m_valid high in cycle t+2.
- resync:
  - Next state is HUNT and bit_cnt=0.
  - resync wins over a simultaneous bit event; that event is ignored.
  - m_valid/m_data are unaffected, so a pending word is still delivered.
  - In HUNT, the sync compare resumes from the next bit event.
- overflow:
  - Cleared by clr_ovf.
  - If a drop and clr_ovf occur in the same cycle, the set wins.
- The sync word is not re-checked once LOCKED; lock is lost only via resync or reset.
- en held high continuously gives a bit event every cycle; full throughput is supported.

Optional Feature:
Macro: SIPO_FRAMER_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt, 8 bits: a saturating count of dropped words (stops at 255).
  - Cleared by reset and by clr_ovf; increment wins on coincidence, so the count becomes 1.
- Undefined: port and counter are absent; overflow behaviour is unchanged.

Decomposition:
- Package sipo_framer_pkg:
  - state encoding constants ST_HUNT=1'b0, ST_LOCKED=1'b1.
  - DROP_CNT_W=8.
- One natural sub-module: sipo_framer_outreg.
  - Holds the one-entry output register with the valid/ready/overflow logic.
  - Inputs: load strobe and word. Outputs: m_data, m_valid, overflow.
- The top level holds en_d, the FSM and bit_cnt.

Test Plan:
1. WIDTH=8. Shift 0xA5 then 0x3C, MSB first, en=1 every cycle, m_ready=1 -> locked rises the cycle after the 8th bit's event; m_data=0x3C with m_valid for exactly 1 cycle, 2 cycles after the last en.
2. Send 0x00, then 0xA5, then 0x11, 0x22, 0x33 with en duty 1-of-3 cycles -> three words 0x11, 0x22, 0x33 in order; no output before the sync word.
3. After sync, m_ready=0; send 0x44 then 0x55 -> m_data holds 0x44 and overflow=1; with the macro on, drop_cnt=1. Then m_ready=1 -> 0x44 accepted. Then clr_ovf -> overflow=0.
4. Assert resync on the same cycle as the 4th bit event of a word -> locked=0 next cycle; that partial word is never output; re-sending 0xA5 then 0x66 yields 0x66.
5. Assert rst_n low mid-word with m_valid=1 -> all outputs 0 immediately (asynchronously); after release the block stays in HUNT until 0xA5 is seen.
6. Continuous back-to-back words with m_ready=1 -> a capture lands in the same cycle as a transfer with no bubble; overflow stays 0 across 10 words.
